mandelbrot_scheduler: RTL and testbench
=======================================

# mandelbrot_scheduler

Frame-level controller that sequences pixel coordinates into the Mandelbrot iteration pipe and writes the returned colours into the display frame buffer. Sits between the address generator / iteration pipe and the frame-buffer write port, replacing free-running FIFO-full gating with an explicit valid/ready issue handshake, an in-flight credit limit and a frame start/done protocol. The pipe returns results strictly in issue order, so write addresses come from a separate counter.

## Interface
- `H_ACTIVE`, default 64: frame width in pixels.
- `V_ACTIVE`, default 48: frame height in pixels.
- `MAX_INFLIGHT`, default 16: maximum number of pixels issued but not yet returned.
- `COLOR_W`, default 9: colour word width (3:3:3 RGB).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begin one frame; sampled only in IDLE.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when the frame is complete.
- `err`, out, 1: sticky protocol error; cleared by `reset` or by an accepted `start`.
- `issue_valid`, out, 1: coordinate offered to the pipe.
- `issue_ready`, in, 1: pipe accepts the coordinate.
- `issue_x`, out, clog2(H_ACTIVE): column.
- `issue_y`, out, clog2(V_ACTIVE): row.
- `result_valid`, in, 1: pipe presents a colour. This signal has no backpressure.
- `result_color`, in, COLOR_W: iteration colour.
- `fb_we`, out, 1: frame-buffer write strobe.
- `fb_addr`, out, clog2(H_ACTIVE*V_ACTIVE): linear address, y*H_ACTIVE+x.
- `fb_wdata`, out, COLOR_W: colour to write.
- `inflight`, out, clog2(MAX_INFLIGHT+1): current outstanding count.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset state is IDLE.
- Reset values: all outputs 0. Issue counters, write counter and inflight are also 0.
- **IDLE:** `start` moves to RUN and clears counters and `err`.
- **RUN:**
  - `issue_valid` = (inflight < MAX_INFLIGHT).
  - A handshake occurs when `issue_valid` && `issue_ready`.
  - On handshake, x increments. At x = H_ACTIVE-1, x wraps to 0 and y increments.
  - The handshake on the pixel (H_ACTIVE-1, V_ACTIVE-1) moves to DRAIN.
  - `issue_x`/`issue_y` stay stable while `issue_valid` is high and not accepted.
- **DRAIN:** `issue_valid` = 0. When the write counter reaches H_ACTIVE*V_ACTIVE, move to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- Results are accepted in RUN and DRAIN. Each result increments the write counter and decrements inflight.
- Inflight arithmetic:
  - Issue and result in the same cycle: inflight unchanged.
  - Issue only: +1.
  - Result only: -1.
- Error conditions, each of which sets `err`:
  - `result_valid` in IDLE or DONE. The result is not written.
  - `result_valid` with inflight = 0 in RUN or DRAIN. The result is not written and inflight does not underflow.
- `start` while busy is ignored and is not an error.
- An asynchronous `reset` mid-frame aborts immediately: IDLE, all outputs 0, outstanding results discarded.

## Timing
- `start` sampled high at edge 0 means `busy` and `issue_valid` are high after edge 0. The first handshake is possible in cycle 1.
- Issue throughput is 1 pixel/cycle while inflight < MAX_INFLIGHT and `issue_ready` is high.
- Write latency is 1 cycle: `result_valid` at edge n gives `fb_we`/`fb_addr`/`fb_wdata` registered and valid after edge n.
- `done` is asserted in the cycle after the last result is sampled, coincident with the last `fb_we`. `busy` falls in that same cycle.
- A back-to-back frame is possible: `start` may be asserted in the cycle after `done`.

## Structure
- Shared package `mandelbrot_pkg`:
  - FSM state enum.
  - The `H_ACTIVE`/`V_ACTIVE` defaults.
  - `COLOR_W`.
  - Address-width helper constants.
- Sub-module `raster_counter`: an x/y counter with enable, wrap, and a last-pixel flag. There are two instances:
  - the issue counter;
  - the write address counter, as a linear counter with a terminal flag.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=2, MAX_INFLIGHT=2.

1. Reset then idle → all outputs 0. `result_valid` pulse → `err`=1 and no `fb_we`.
2. `start` with `issue_ready`=1 and no results → exactly 2 handshakes, (0,0) then (1,0). Then `issue_valid`=0 with inflight=2.
3. Full frame with `result_valid` 3 cycles after each issue and colours 1..8:
   - `fb_addr` 0..7 carries colours 1..8 in order.
   - `done` is a single pulse with the last write.
   - `busy` then drops.
4. `issue_ready` toggled 1/0 every cycle → coordinates held stable while stalled. All 8 pixels are issued in raster order with x wrapping 3→0, y 0→1.
5. Simultaneous issue and result at inflight=1 → inflight stays 1. `start` during RUN is ignored.
6. `reset` asserted mid-DRAIN with inflight=2 → immediate IDLE with outputs 0. A new `start` produces a clean frame with `fb_addr` starting at 0.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot frame scheduler.
// Holds the FSM state encoding, the default frame geometry and the address-width helpers.
package mandelbrot_pkg;

  localparam int H_ACTIVE_DEF = 64;
  localparam int V_ACTIVE_DEF = 48;
  localparam int MAX_INFLIGHT_DEF = 16;
  localparam int COLOR_W = 9;

  // Counter width for n states; never narrower than one bit so degenerate geometries still elaborate.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W_DEF = cw(H_ACTIVE_DEF);
  localparam int Y_W_DEF = cw(V_ACTIVE_DEF);
  localparam int ADDR_W_DEF = cw(H_ACTIVE_DEF * V_ACTIVE_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter with a synchronous clear, a count enable and a last-pixel flag.
// Both the coordinate issue side and the frame-buffer write side of the scheduler use it.
module raster_counter
  import mandelbrot_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  output logic [cw(H_ACTIVE)-1:0] x,
  output logic [cw(V_ACTIVE)-1:0] y,
  output logic                    last
);

  localparam int XW = cw(H_ACTIVE);
  localparam int YW = cw(V_ACTIVE);

  logic x_end;
  logic y_end;

  assign x_end = (x == XW'(H_ACTIVE - 1));
  assign y_end = (y == YW'(V_ACTIVE - 1));
  assign last  = x_end && y_end;

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame controller: issues raster coordinates to the iteration pipe under a credit limit
// and writes the in-order colour results to the frame buffer, with start/busy/done handshaking.
module mandelbrot_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int COLOR_W      = mandelbrot_pkg::COLOR_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                issue_valid,
  input  logic                                issue_ready,
  output logic [cw(H_ACTIVE)-1:0]             issue_x,
  output logic [cw(V_ACTIVE)-1:0]             issue_y,
  input  logic                                result_valid,
  input  logic [COLOR_W-1:0]                  result_color,
  output logic                                fb_we,
  output logic [cw(H_ACTIVE*V_ACTIVE)-1:0]    fb_addr,
  output logic [COLOR_W-1:0]                  fb_wdata,
  output logic [cw(MAX_INFLIGHT+1)-1:0]       inflight
);

  localparam int XW = cw(H_ACTIVE);
  localparam int YW = cw(V_ACTIVE);
  localparam int AW = cw(H_ACTIVE * V_ACTIVE);
  localparam int IW = cw(MAX_INFLIGHT + 1);

  state_t state;

  logic          frame_start;
  logic          issue_hs;
  logic          issue_last;
  logic          res_active;
  logic          res_accept;
  logic          res_error;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic          wr_last;
  logic [AW-1:0] wr_addr;

  assign frame_start = (state == ST_IDLE) && start;
  assign issue_valid = (state == ST_RUN) && (inflight < IW'(MAX_INFLIGHT));
  assign issue_hs    = issue_valid && issue_ready;

  // A result with nothing outstanding is a pipe protocol fault; it is dropped, never written.
  assign res_active = (state == ST_RUN) || (state == ST_DRAIN);
  assign res_accept = result_valid && res_active && (inflight != '0);
  assign res_error  = result_valid && !res_accept;

  assign wr_addr = AW'(wr_y) * AW'(H_ACTIVE) + AW'(wr_x);

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (frame_start),
    .en    (issue_hs),
    .x     (issue_x),
    .y     (issue_y),
    .last  (issue_last)
  );

  // Results return in issue order, so the write side simply walks the raster again.
  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_write_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (frame_start),
    .en    (res_accept),
    .x     (wr_x),
    .y     (wr_y),
    .last  (wr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      inflight <= '0;
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;

      if (res_accept) begin
        fb_we    <= 1'b1;
        fb_addr  <= wr_addr;
        fb_wdata <= result_color;
      end

      // A fault in the same cycle as the start still leaves err set.
      if (frame_start) err <= 1'b0;
      if (res_error)   err <= 1'b1;

      if (frame_start) begin
        inflight <= '0;
      end else if (issue_hs && !res_accept) begin
        inflight <= inflight + IW'(1);
      end else if (!issue_hs && res_accept) begin
        inflight <= inflight - IW'(1);
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue_hs && issue_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (res_accept && wr_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Directed bench for mandelbrot_scheduler on a 4x2 frame with a credit limit of 2.
module tb_mandelbrot_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int M  = 2;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          issue_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic [CW-1:0] result_color = '0;
  logic          busy, done, err, issue_valid, fb_we;
  logic [1:0]    issue_x;
  logic [0:0]    issue_y;
  logic [2:0]    fb_addr;
  logic [CW-1:0] fb_wdata;
  logic [1:0]    inflight;

  int n_checks = 0;
  int n_errors = 0;

  int iss_x_q[$];
  int iss_y_q[$];
  int wr_a_q[$];
  int wr_d_q[$];
  int done_cnt;
  int done_we;
  int done_addr;
  int done_busy;

  mandelbrot_scheduler #(
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .MAX_INFLIGHT (M),
    .COLOR_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_x      (issue_x),
    .issue_y      (issue_y),
    .result_valid (result_valid),
    .result_color (result_color),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Runs one frame: results return `delay` cycles after each handshake, colours 1,2,3...
  task automatic run_frame(input bit toggle, input int delay, input int max_cyc);
    int due[$];
    int nres;
    int hx;
    int hy;
    bit held;
    iss_x_q.delete(); iss_y_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    done_cnt = 0; done_we = 0; done_addr = -1; done_busy = -1;
    nres = 0; held = 1'b0; hx = 0; hy = 0;
    start = 1'b1; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (fb_we) begin
        wr_a_q.push_back(int'(fb_addr));
        wr_d_q.push_back(int'(fb_wdata));
      end
      if (held && issue_valid) begin
        check("hold_x", int'(issue_x), hx);
        check("hold_y", int'(issue_y), hy);
      end
      if (done) begin
        done_cnt++;
        done_we = int'(fb_we);
        done_addr = int'(fb_addr);
        done_busy = int'(busy);
        result_valid = 1'b0; issue_ready = 1'b0;
        tick();
        if (done) done_cnt++;
        break;
      end
      issue_ready  = toggle ? (cyc % 2 == 1) : 1'b1;
      result_valid = (due.size() > 0) && (due[0] == cyc);
      if (result_valid) begin
        void'(due.pop_front());
        nres++;
        result_color = CW'(nres);
      end
      if (issue_valid && issue_ready) begin
        iss_x_q.push_back(int'(issue_x));
        iss_y_q.push_back(int'(issue_y));
        due.push_back(cyc + delay);
        held = 1'b0;
      end else if (issue_valid) begin
        held = 1'b1; hx = int'(issue_x); hy = int'(issue_y);
      end else begin
        held = 1'b0;
      end
      tick();
    end
    result_valid = 1'b0;
    issue_ready  = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_writes"}, wr_a_q.size(), H * V);
    for (int i = 0; i < wr_a_q.size(); i++) begin
      check({tag, "_addr"}, wr_a_q[i], i);
      check({tag, "_data"}, wr_d_q[i], i + 1);
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_with_we"}, done_we, 1);
    check({tag, "_done_addr"}, done_addr, H * V - 1);
    check({tag, "_busy_at_done"}, done_busy, 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int hs_x[$];
    int hs_y[$];
    int issued;
    int returned;

    // 1: reset state and a stray result in IDLE
    #12;
    reset = 1'b0;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_issue_valid", int'(issue_valid), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_inflight", int'(inflight), 0);
    result_valid = 1'b1; result_color = CW'(3);
    tick();
    result_valid = 1'b0;
    check("idle_result_err", int'(err), 1);
    check("idle_result_no_we", int'(fb_we), 0);

    // 2: credit limit stops issue at two outstanding
    start = 1'b1; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_issue_valid", int'(issue_valid), 1);
    check("start_err_cleared", int'(err), 0);
    for (int c = 0; c < 6; c++) begin
      if (issue_valid && issue_ready) begin
        hs_x.push_back(int'(issue_x));
        hs_y.push_back(int'(issue_y));
      end
      tick();
    end
    check("credit_handshakes", hs_x.size(), 2);
    if (hs_x.size() == 2) begin
      check("credit_hs0_x", hs_x[0], 0);
      check("credit_hs0_y", hs_y[0], 0);
      check("credit_hs1_x", hs_x[1], 1);
      check("credit_hs1_y", hs_y[1], 0);
    end
    check("credit_valid_low", int'(issue_valid), 0);
    check("credit_inflight", int'(inflight), 2);
    issue_ready = 1'b0;
    do_reset();

    // 3: full frame, results three cycles after each issue
    run_frame(1'b0, 3, 200);
    check_frame("frame");

    // 4: issue_ready toggling, raster order and held coordinates
    run_frame(1'b1, 3, 200);
    check("toggle_issued", iss_x_q.size(), H * V);
    for (int i = 0; i < iss_x_q.size(); i++) begin
      check("toggle_order_x", iss_x_q[i], i % H);
      check("toggle_order_y", iss_y_q[i], i / H);
    end
    check_frame("toggle");

    // 5: simultaneous issue and result, start ignored while busy
    do_reset();
    start = 1'b1; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sim_inflight_before", int'(inflight), 1);
    result_valid = 1'b1; result_color = CW'(5); start = 1'b1;
    tick();
    check("sim_inflight", int'(inflight), 1);
    check("sim_issue_x", int'(issue_x), 2);
    check("sim_fb_we", int'(fb_we), 1);
    check("sim_fb_addr", int'(fb_addr), 0);
    check("sim_fb_wdata", int'(fb_wdata), 5);
    check("sim_busy", int'(busy), 1);
    check("sim_err", int'(err), 0);
    result_valid = 1'b0; issue_ready = 1'b0;
    tick();
    start = 1'b0;
    check("busy_start_ignored_x", int'(issue_x), 2);
    check("busy_start_ignored_inflight", int'(inflight), 1);
    check("busy_start_no_err", int'(err), 0);

    // 6: reset in DRAIN with two outstanding, then a clean frame
    do_reset();
    start = 1'b1; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    issued = 0; returned = 0;
    for (int c = 0; c < 40; c++) begin
      result_valid = (issued - returned > 0) && (returned < H * V - 2);
      if (result_valid) begin
        returned++;
        result_color = CW'(returned);
      end
      if (issue_valid && issue_ready) issued++;
      tick();
      if (issued == H * V && returned == H * V - 2) break;
    end
    result_valid = 1'b0; issue_ready = 1'b0;
    check("drain_busy", int'(busy), 1);
    check("drain_issue_valid", int'(issue_valid), 0);
    check("drain_inflight", int'(inflight), 2);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_inflight", int'(inflight), 0);
    check("abort_issue_valid", int'(issue_valid), 0);
    check("abort_fb_we", int'(fb_we), 0);
    check("abort_done", int'(done), 0);
    #1;
    reset = 1'b0;
    run_frame(1'b0, 3, 200);
    check_frame("restart");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
